soc_bus_decoder: RTL and testbench



---
 rtl/soc_bus_pkg.sv | 22 ++
 rtl/soc_bus_decoder_if.sv | 41 ++++
 rtl/soc_addr_decode.sv | 39 +++
 rtl/soc_bus_decoder.sv | 138 +++++++++++++
 tb/tb_soc_bus_decoder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and defaults for the SoC memory-bus decoder.
package soc_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int ID_FIELD_W  = 8;
    localparam int ERR_COUNT_W = 16;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    // Entry i lives at bits [i*ID_FIELD_W +: ID_FIELD_W]; target 0 is 8'h00.
    localparam logic [6*ID_FIELD_W-1:0] DEFAULT_TARGET_IDS =
        {8'h0F, 8'h05, 8'h04, 8'h03, 8'h02, 8'h00};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_bus_decoder_if.sv
// Host port plus fan-out target port of the memory-bus decoder.
interface soc_bus_decoder_if
    import soc_bus_pkg::*;
#(
    parameter int NUM_TARGETS = 6,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [DATA_WIDTH-1:0]             mem_wdata;
    logic [DATA_WIDTH/8-1:0]           mem_wmask;
    logic                              mem_wstrb;
    logic                              mem_rstrb;
    logic [DATA_WIDTH-1:0]             mem_rdata;
    logic                              mem_done;
    logic                              bus_err;
    logic [ERR_COUNT_W-1:0]            err_count;

    logic [ADDR_WIDTH-1:0]             t_addr;
    logic [DATA_WIDTH-1:0]             t_wdata;
    logic [DATA_WIDTH/8-1:0]           t_wmask;
    logic [NUM_TARGETS-1:0]            t_sel;
    logic [NUM_TARGETS-1:0]            t_wstrb;
    logic [NUM_TARGETS-1:0]            t_rstrb;
    logic [NUM_TARGETS*DATA_WIDTH-1:0] t_rdata;
    logic [NUM_TARGETS-1:0]            t_done;

    // master drives the host fields and the target responses
    modport master (
        output mem_addr, mem_wdata, mem_wmask, mem_wstrb, mem_rstrb, t_rdata, t_done,
        input  mem_rdata, mem_done, bus_err, err_count,
               t_addr, t_wdata, t_wmask, t_sel, t_wstrb, t_rstrb
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wmask, mem_wstrb, mem_rstrb, t_rdata, t_done,
        output mem_rdata, mem_done, bus_err, err_count,
               t_addr, t_wdata, t_wmask, t_sel, t_wstrb, t_rstrb
    );

endinterface

// File: rtl/soc_addr_decode.sv
// Combinational target-ID decode: one-hot hit, lowest matching index, miss flag.
module soc_addr_decode
    import soc_bus_pkg::*;
#(
    parameter int NUM_TARGETS = 6,
    parameter int ID_W        = ID_FIELD_W,
    parameter int IDX_W       = idx_width(NUM_TARGETS)
) (
    input  logic [ID_W-1:0]             i_id,
    input  logic [NUM_TARGETS*ID_W-1:0] i_target_ids,
    output logic [NUM_TARGETS-1:0]      o_hit,
    output logic [IDX_W-1:0]            o_idx,
    output logic                        o_miss
);

    logic [NUM_TARGETS-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_match
            assign w_match[gi] = (i_id == i_target_ids[gi*ID_W +: ID_W]);
        end
    endgenerate

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        o_hit  = '0;
        o_idx  = '0;
        o_miss = ~|w_match;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit    = '0;
                o_hit[i] = 1'b1;
                o_idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/soc_bus_decoder.sv
// Memory-bus decoder/return mux: routes host strobes to N targets, waits for done,
// and answers unmapped or timed-out accesses with an error response.
module soc_bus_decoder
    import soc_bus_pkg::*;
#(
    parameter int                                          NUM_TARGETS    = 6,
    parameter int                                          ADDR_WIDTH     = 32,
    parameter int                                          DATA_WIDTH     = 32,
    parameter int                                          SEL_LSB        = 24,
    parameter logic [NUM_TARGETS*(ADDR_WIDTH-SEL_LSB)-1:0] TARGET_IDS     = DEFAULT_TARGET_IDS,
    parameter int                                          TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0]                       ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic           clk,
    input  logic           reset,
    soc_bus_decoder_if.slave bus
);

    localparam int ID_W  = ADDR_WIDTH - SEL_LSB;
    localparam int IDX_W = idx_width(NUM_TARGETS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 r_state, w_state_next;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_is_read;
    logic [CNT_W-1:0]       r_count;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [ERR_COUNT_W-1:0] r_err_count;

    logic [NUM_TARGETS-1:0] w_hit, w_wait_sel, w_sel, w_wstrb, w_rstrb;
    logic [IDX_W-1:0]       w_dec_idx, w_src_idx;
    logic                   w_miss, w_strobe, w_is_write, w_is_read;
    logic                   w_done, w_err, w_latch, w_cap_data, w_cap_err;
    logic [DATA_WIDTH-1:0]  w_src_rdata;

    soc_addr_decode #(
        .NUM_TARGETS (NUM_TARGETS),
        .ID_W        (ID_W),
        .IDX_W       (IDX_W)
    ) u_decode (
        .i_id         (bus.mem_addr[ADDR_WIDTH-1:SEL_LSB]),
        .i_target_ids (TARGET_IDS),
        .o_hit        (w_hit),
        .o_idx        (w_dec_idx),
        .o_miss       (w_miss)
    );

    // A simultaneous write and read strobe is treated as a write.
    assign w_strobe    = bus.mem_wstrb | bus.mem_rstrb;
    assign w_is_write  = bus.mem_wstrb;
    assign w_is_read   = bus.mem_rstrb & ~bus.mem_wstrb;
    assign w_wait_sel  = NUM_TARGETS'(1) << r_idx;
    assign w_src_rdata = bus.t_rdata[w_src_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_state_next = r_state;
        w_sel        = '0;
        w_wstrb      = '0;
        w_rstrb      = '0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_latch      = 1'b0;
        w_cap_data   = 1'b0;
        w_cap_err    = 1'b0;
        w_src_idx    = r_idx;
        case (r_state)
            IDLE: begin
                w_sel     = w_hit;
                w_src_idx = w_dec_idx;
                if (w_strobe) begin
                    if (w_miss) begin
                        w_done    = 1'b1;
                        w_err     = 1'b1;
                        w_cap_err = w_is_read;
                    end else begin
                        w_latch = 1'b1;
                        if (w_is_write) w_wstrb = w_hit;
                        else            w_rstrb = w_hit;
                        if (bus.t_done[w_dec_idx]) begin
                            w_done     = 1'b1;
                            w_cap_data = w_is_read;
                        end else begin
                            w_state_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                // Host strobes here are ignored; only the latched target is watched.
                w_sel = w_wait_sel;
                if (bus.t_done[r_idx]) begin
                    w_done       = 1'b1;
                    w_cap_data   = r_is_read;
                    w_state_next = IDLE;
                end else if (r_count == CNT_W'(TIMEOUT_CYCLES)) begin
                    w_done       = 1'b1;
                    w_err        = 1'b1;
                    w_cap_err    = r_is_read;
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_is_read   <= 1'b0;
            r_count     <= '0;
            r_rdata     <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_idx     <= w_dec_idx;
                r_is_read <= w_is_read;
            end
            r_count <= (r_state == WAIT) ? r_count + CNT_W'(1) : '0;
            if (w_cap_err)       r_rdata <= ERR_DATA;
            else if (w_cap_data) r_rdata <= w_src_rdata;
            if (w_err && (r_err_count != {ERR_COUNT_W{1'b1}}))
                r_err_count <= r_err_count + ERR_COUNT_W'(1);
        end
    end

    assign bus.t_addr    = bus.mem_addr;
    assign bus.t_wdata   = bus.mem_wdata;
    assign bus.t_wmask   = bus.mem_wmask;
    assign bus.t_sel     = w_sel;
    assign bus.t_wstrb   = w_wstrb;
    assign bus.t_rstrb   = w_rstrb;
    assign bus.mem_done  = w_done;
    assign bus.bus_err   = w_err;
    assign bus.mem_rdata = r_rdata;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_soc_bus_decoder.sv
// Directed bench for soc_bus_decoder: one instance with the default timeout,
// a second with TIMEOUT_CYCLES=4 for the abort scenarios.
module tb_soc_bus_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    soc_bus_decoder_if #(.NUM_TARGETS(6), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    soc_bus_decoder_if #(.NUM_TARGETS(6), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    soc_bus_decoder #(.TIMEOUT_CYCLES(255)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    soc_bus_decoder #(.TIMEOUT_CYCLES(4))   dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    task automatic idle_inputs();
        bus_a.mem_wstrb = 1'b0; bus_a.mem_rstrb = 1'b0; bus_a.t_done = '0;
        bus_b.mem_wstrb = 1'b0; bus_b.mem_rstrb = 1'b0; bus_b.t_done = '0;
    endtask

    task automatic test_reset();
        bus_a.mem_addr = 32'h0200_0000; bus_a.mem_wdata = '0; bus_a.mem_wmask = '0;
        bus_b.mem_addr = 32'h0000_0000; bus_b.mem_wdata = '0; bus_b.mem_wmask = '0;
        bus_a.t_rdata = {6{32'h5A5A_A5A5}};
        bus_b.t_rdata = {6{32'h5A5A_A5A5}};
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("[TB] txn reset held");
        tests_run++; if (bus_a.mem_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata: got %h want 00000000", bus_a.mem_rdata); end
        tests_run++; if (bus_a.mem_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b want 0", bus_a.mem_done); end
        tests_run++; if (bus_a.bus_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", bus_a.bus_err); end
        tests_run++; if (bus_a.err_count !== 16'h0) begin tests_failed++; $display("FAIL rst_errcnt: got %h want 0000", bus_a.err_count); end
        tests_run++; if ({bus_a.t_wstrb, bus_a.t_rstrb} !== 12'h0) begin tests_failed++; $display("FAIL rst_strobes: got %b want 0", {bus_a.t_wstrb, bus_a.t_rstrb}); end
        tests_run++; if (bus_a.t_sel !== 6'b000010) begin tests_failed++; $display("FAIL rst_sel_decode: got %b want 000010", bus_a.t_sel); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_latency_write();
        @(negedge clk);
        bus_a.mem_addr = 32'h0000_0010; bus_a.mem_wdata = 32'h1234_5678; bus_a.mem_wmask = 4'hF;
        bus_a.mem_wstrb = 1'b1; bus_a.t_done = 6'b000001;
        #1;
        $display("[TB] txn zero-latency write addr=%h data=%h", bus_a.mem_addr, bus_a.mem_wdata);
        tests_run++; if (bus_a.t_wstrb !== 6'b000001) begin tests_failed++; $display("FAIL zl_wstrb: got %b want 000001", bus_a.t_wstrb); end
        tests_run++; if (bus_a.t_rstrb !== 6'b000000) begin tests_failed++; $display("FAIL zl_rstrb: got %b want 000000", bus_a.t_rstrb); end
        tests_run++; if (bus_a.mem_done !== 1'b1 || bus_a.bus_err !== 1'b0) begin tests_failed++; $display("FAIL zl_done: got done=%b err=%b want 1/0", bus_a.mem_done, bus_a.bus_err); end
        tests_run++; if (bus_a.t_wdata !== 32'h1234_5678 || bus_a.t_addr !== 32'h0000_0010) begin tests_failed++; $display("FAIL zl_bcast: got %h/%h", bus_a.t_addr, bus_a.t_wdata); end
        @(negedge clk);
        idle_inputs();
        bus_a.mem_addr = 32'h0300_0000;
        #1;
        tests_run++; if (bus_a.t_sel !== 6'b000100) begin tests_failed++; $display("FAIL zl_stays_idle: sel got %b want 000100", bus_a.t_sel); end
        tests_run++; if (bus_a.mem_done !== 1'b0 || bus_a.mem_rdata !== 32'h0) begin tests_failed++; $display("FAIL zl_after: done=%b rdata=%h want 0/00000000", bus_a.mem_done, bus_a.mem_rdata); end
    endtask

    task automatic test_wait_read();
        @(negedge clk);
        bus_a.mem_addr = 32'h0200_0100; bus_a.mem_rstrb = 1'b1;
        #1;
        $display("[TB] txn wait-state read addr=%h", bus_a.mem_addr);
        tests_run++; if (bus_a.t_rstrb !== 6'b000010 || bus_a.mem_done !== 1'b0) begin tests_failed++; $display("FAIL wr_issue: rstrb=%b done=%b want 000010/0", bus_a.t_rstrb, bus_a.mem_done); end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bus_a.mem_rstrb = 1'b0;
            bus_a.mem_addr  = 32'h0000_0000;
            bus_a.t_done    = (c == 3) ? 6'b000001 : ((c == 7) ? 6'b000010 : 6'b000000);
            if (c == 7) bus_a.t_rdata[1*32 +: 32] = 32'hCAFE_F00D;
            #1;
            if (c < 7) begin
                tests_run++; if (bus_a.mem_done !== 1'b0 || bus_a.t_sel !== 6'b000010) begin tests_failed++; $display("FAIL wr_wait_c%0d: done=%b sel=%b want 0/000010", c, bus_a.mem_done, bus_a.t_sel); end
            end else begin
                tests_run++; if (bus_a.mem_done !== 1'b1 || bus_a.bus_err !== 1'b0) begin tests_failed++; $display("FAIL wr_done: done=%b err=%b want 1/0", bus_a.mem_done, bus_a.bus_err); end
                tests_run++; if (bus_a.mem_rdata !== 32'h0) begin tests_failed++; $display("FAIL wr_rdata_early: got %h want 00000000", bus_a.mem_rdata); end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++; if (bus_a.mem_rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL wr_rdata: got %h want cafef00d", bus_a.mem_rdata); end
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        bus_a.mem_addr = 32'h0700_0000; bus_a.mem_rstrb = 1'b1;
        #1;
        $display("[TB] txn unmapped read addr=%h", bus_a.mem_addr);
        tests_run++; if (bus_a.mem_done !== 1'b1 || bus_a.bus_err !== 1'b1) begin tests_failed++; $display("FAIL um_done: done=%b err=%b want 1/1", bus_a.mem_done, bus_a.bus_err); end
        tests_run++; if (bus_a.t_sel !== 6'b0 || bus_a.t_rstrb !== 6'b0) begin tests_failed++; $display("FAIL um_sel: sel=%b rstrb=%b want 0/0", bus_a.t_sel, bus_a.t_rstrb); end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++; if (bus_a.mem_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL um_rdata: got %h want deadbeef", bus_a.mem_rdata); end
        tests_run++; if (bus_a.err_count !== 16'd1) begin tests_failed++; $display("FAIL um_errcnt: got %0d want 1", bus_a.err_count); end
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            bus_b.mem_addr = 32'h0400_0000; bus_b.mem_rstrb = 1'b1;
            #1;
            $display("[TB] txn timeout read target 3 pass=%0d", pass);
            tests_run++; if (bus_b.t_rstrb !== 6'b001000) begin tests_failed++; $display("FAIL to_issue_p%0d: rstrb=%b want 001000", pass, bus_b.t_rstrb); end
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                bus_b.mem_rstrb = 1'b0;
                bus_b.t_done = (pass == 1 && c == 5) ? 6'b001000 : 6'b000000;
                if (pass == 1 && c == 5) bus_b.t_rdata[3*32 +: 32] = 32'h0BAD_CAFE;
                #1;
                if (c < 5) begin
                    tests_run++; if (bus_b.mem_done !== 1'b0) begin tests_failed++; $display("FAIL to_wait_p%0d_c%0d: done=%b want 0", pass, c, bus_b.mem_done); end
                end else begin
                    tests_run++; if (bus_b.mem_done !== 1'b1 || bus_b.bus_err !== (pass == 0)) begin tests_failed++; $display("FAIL to_end_p%0d: done=%b err=%b want 1/%0d", pass, bus_b.mem_done, bus_b.bus_err, (pass == 0)); end
                end
            end
            @(negedge clk);
            idle_inputs();
            #1;
            tests_run++; if (bus_b.mem_rdata !== ((pass == 0) ? 32'hDEAD_BEEF : 32'h0BAD_CAFE)) begin tests_failed++; $display("FAIL to_rdata_p%0d: got %h", pass, bus_b.mem_rdata); end
            tests_run++; if (bus_b.err_count !== 16'd1) begin tests_failed++; $display("FAIL to_errcnt_p%0d: got %0d want 1", pass, bus_b.err_count); end
        end
    endtask

    task automatic test_both_strobes_and_wait_strobe();
        @(negedge clk);
        bus_a.mem_addr = 32'h0500_0000; bus_a.mem_wstrb = 1'b1; bus_a.mem_rstrb = 1'b1;
        #1;
        $display("[TB] txn dual-strobe access target 4");
        tests_run++; if (bus_a.t_wstrb !== 6'b010000 || bus_a.t_rstrb !== 6'b0) begin tests_failed++; $display("FAIL bs_strobes: w=%b r=%b want 010000/0", bus_a.t_wstrb, bus_a.t_rstrb); end
        @(negedge clk);
        bus_a.mem_wstrb = 1'b0; bus_a.mem_rstrb = 1'b1; bus_a.mem_addr = 32'h0000_0000;
        #1;
        $display("[TB] txn strobe during WAIT (ignored)");
        tests_run++; if (bus_a.t_wstrb !== 6'b0 || bus_a.t_rstrb !== 6'b0 || bus_a.mem_done !== 1'b0) begin tests_failed++; $display("FAIL bs_wait_strobe: w=%b r=%b done=%b want 0/0/0", bus_a.t_wstrb, bus_a.t_rstrb, bus_a.mem_done); end
        tests_run++; if (bus_a.t_sel !== 6'b010000) begin tests_failed++; $display("FAIL bs_wait_sel: got %b want 010000", bus_a.t_sel); end
        @(negedge clk);
        bus_a.mem_rstrb = 1'b0; bus_a.t_done = 6'b010000; bus_a.t_rdata[4*32 +: 32] = 32'h1111_1111;
        #1;
        tests_run++; if (bus_a.mem_done !== 1'b1 || bus_a.bus_err !== 1'b0) begin tests_failed++; $display("FAIL bs_done: done=%b err=%b want 1/0", bus_a.mem_done, bus_a.bus_err); end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++; if (bus_a.mem_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL bs_rdata_kept: got %h want deadbeef", bus_a.mem_rdata); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        bus_a.mem_addr = 32'h0300_0000; bus_a.mem_rstrb = 1'b1;
        #1;
        $display("[TB] txn read target 2 aborted by reset");
        tests_run++; if (bus_a.t_rstrb !== 6'b000100) begin tests_failed++; $display("FAIL rw_issue: rstrb=%b want 000100", bus_a.t_rstrb); end
        @(negedge clk);
        bus_a.mem_rstrb = 1'b0; bus_a.mem_addr = 32'h0F00_0000;
        #1;
        tests_run++; if (bus_a.t_sel !== 6'b000100) begin tests_failed++; $display("FAIL rw_in_wait: sel=%b want 000100", bus_a.t_sel); end
        #1;
        reset = 1'b1;
        bus_a.t_done = 6'b000100;
        #1;
        tests_run++; if (bus_a.t_sel !== 6'b100000 || bus_a.mem_done !== 1'b0) begin tests_failed++; $display("FAIL rw_reset: sel=%b done=%b want 100000/0", bus_a.t_sel, bus_a.mem_done); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        tests_run++; if (bus_a.mem_rdata !== 32'h0 || bus_a.err_count !== 16'h0) begin tests_failed++; $display("FAIL rw_cleared: rdata=%h errcnt=%h want 0/0", bus_a.mem_rdata, bus_a.err_count); end
        @(negedge clk);
        bus_a.t_done = 6'b000100;
        #1;
        tests_run++; if (bus_a.mem_done !== 1'b0) begin tests_failed++; $display("FAIL rw_stray_done: done=%b want 0", bus_a.mem_done); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        bus_a.mem_addr = 32'h0700_0000; bus_a.mem_rstrb = 1'b1;
        $display("[TB] txn 65540 back-to-back unmapped reads");
        repeat (65534) @(posedge clk);
        #1;
        tests_run++; if (bus_a.err_count !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_near: got %h want fffe", bus_a.err_count); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++; if (bus_a.err_count !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_final: got %h want ffff", bus_a.err_count); end
    endtask

    initial begin
        test_reset();
        test_zero_latency_write();
        test_wait_read();
        test_unmapped();
        test_timeout();
        test_both_strobes_and_wait_strobe();
        test_reset_in_wait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
